matrix_operand_loader: RTL and testbench

MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

---
 rtl/matrix_operand_loader_if.sv | 25 ++
 rtl/matrix_operand_loader.sv | 105 ++++++++++
 tb/tb_matrix_operand_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/matrix_operand_loader_if.sv
// rtl/matrix_operand_loader_if.sv - element stream in, registered A/B operand pair out
// master drives the element stream and consumes the pair; slave is the loader.
interface matrix_operand_loader_if #(
  parameter int L = 1,
  parameter int M = 1,
  parameter int N = 1
);
  logic [31:0]        in_data;
  logic               in_valid;
  logic               in_ready;
  logic [32*L*M-1:0]  A;
  logic [32*M*N-1:0]  B;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, A, B, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, A, B, out_valid
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// rtl/matrix_operand_loader.sv - collects row-major A then B from a word stream
// and holds the pair for a combinational multiplier until it is consumed.
module matrix_operand_loader #(
  parameter int L = 1,
  parameter int M = 1,
  parameter int N = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_operand_loader_if.slave  bus
);

  localparam int NA   = L * M;
  localparam int NB   = M * N;
  localparam int NMAX = (NA > NB) ? NA : NB;
  localparam int CW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [32*NA-1:0]  a_q, a_d;
  logic [32*NB-1:0]  b_q, b_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready;
  logic              xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Elements not yet rewritten keep their old words; out_valid low marks them stale.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      LOAD_A: begin
        if (xfer) begin
          for (int k = 0; k < NA; k++) begin
            if (cnt_q == CW'(k)) a_d[32*k +: 32] = bus.in_data;
          end
          if (cnt_q == CW'(NA - 1)) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          for (int k = 0; k < NB; k++) begin
            if (cnt_q == CW'(k)) b_d[32*k +: 32] = bus.in_data;
          end
          if (cnt_q == CW'(NB - 1)) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          cnt_d   = '0;
          state_d = LOAD_A;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = LOAD_A;
      end
    endcase
    out_valid_d = (state_d == HOLD);
  end

  always_comb begin
    in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    xfer     = bus.in_valid && in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb/tb_matrix_operand_loader.sv - scoreboard bench for a 2x3*3x2 loader and a 1x1 loader
module tb_matrix_operand_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  matrix_operand_loader_if #(.L(2), .M(3), .N(2)) bus0 ();
  matrix_operand_loader_if #(.L(1), .M(1), .N(1)) bus1 ();

  matrix_operand_loader #(.L(2), .M(3), .N(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  matrix_operand_loader #(.L(1), .M(1), .N(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  typedef struct {
    logic [191:0] a;
    logic [191:0] b;
    int           cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  logic [31:0] stream1 [12] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000,
    32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000
  };
  logic [31:0] words [12];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] pack6(input int base);
    logic [191:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) r[32*k +: 32] = words[base + k];
    return r;
  endfunction

  task automatic send_stream(input int stall_after, input int stall_len);
    exp_t e;
    e.a   = pack6(0);
    e.b   = pack6(6);
    e.cyc = cyc + 12 + stall_len;
    q0.push_back(e);
    for (int i = 0; i < 12; i++) begin
      if (i == stall_after) begin
        bus0.in_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          bus0.in_data = 32'hDEAD0000 + s;
          step();
        end
      end
      chk("out_valid_low_during_load", 192'(bus0.out_valid), 192'(0));
      bus0.in_valid = 1'b1;
      bus0.in_data  = words[i];
      step();
    end
    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;
  endtask

  task automatic pulse_out_ready();
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    step();
    bus0.out_ready = 1'b0;
    chk("out_valid_after_release", 192'(bus0.out_valid), 192'(0));
    chk("in_ready_after_release", 192'(bus0.in_ready), 192'(1));
  endtask

  logic ov_prev0 = 1'b0;
  always @(negedge clk) begin
    if (bus0.out_valid && !ov_prev0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair0: out_valid rose at cycle %0d, required no pair", cyc);
      end else begin
        m0 = q0.pop_front();
        chk("pair0_A", 192'(bus0.A), m0.a);
        chk("pair0_B", 192'(bus0.B), m0.b);
        chk("pair0_valid_cycle", 192'(cyc), 192'(m0.cyc));
        chk("pair0_in_ready_hold", 192'(bus0.in_ready), 192'(0));
      end
    end
    ov_prev0 = bus0.out_valid;
  end

  logic ov_prev1 = 1'b0;
  always @(negedge clk) begin
    if (bus1.out_valid && !ov_prev1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair1: out_valid rose at cycle %0d, required no pair", cyc);
      end else begin
        m1 = q1.pop_front();
        chk("pair1_A", 192'(bus1.A), m1.a);
        chk("pair1_B", 192'(bus1.B), m1.b);
        chk("pair1_valid_cycle", 192'(cyc), 192'(m1.cyc));
        chk("pair1_in_ready_hold", 192'(bus1.in_ready), 192'(0));
      end
    end
    ov_prev1 = bus1.out_valid;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1;
    logic [191:0] hold_a, hold_b;
    bus0.in_data = '0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    bus1.in_data = '0; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    step();
    step();
    chk("reset_A", 192'(bus0.A), 192'(0));
    chk("reset_B", 192'(bus0.B), 192'(0));
    chk("reset_out_valid", 192'(bus0.out_valid), 192'(0));
    chk("reset_in_ready", 192'(bus0.in_ready), 192'(1));
    rst = 1'b0;
    step();

    // basic 12-word load
    for (int i = 0; i < 12; i++) words[i] = stream1[i];
    send_stream(-1, 0);
    chk("A_elem0", 192'(bus0.A[31:0]), 192'(32'h3F800000));
    chk("A_elem5", 192'(bus0.A[191:160]), 192'(32'h40C00000));

    // hold with out_ready low and junk offered on the input
    hold_a = pack6(0);
    hold_b = pack6(6);
    for (int c = 0; c < 10; c++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = 32'h12340000 + c;
      step();
      chk("hold_A", 192'(bus0.A), hold_a);
      chk("hold_B", 192'(bus0.B), hold_b);
      chk("hold_in_ready", 192'(bus0.in_ready), 192'(0));
      chk("hold_out_valid", 192'(bus0.out_valid), 192'(1));
    end
    pulse_out_ready();

    // same stream with a 3-cycle stall after the 4th word
    send_stream(4, 3);
    pulse_out_ready();

    // back-to-back: negated words must fully replace the previous pair
    for (int i = 0; i < 12; i++) words[i] = stream1[i] ^ 32'h80000000;
    send_stream(-1, 0);
    pulse_out_ready();

    // reset after 8 transfers
    for (int i = 0; i < 12; i++) words[i] = stream1[i];
    for (int i = 0; i < 8; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = words[i];
      step();
    end
    bus0.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_A", 192'(bus0.A), 192'(0));
    chk("midrst_B", 192'(bus0.B), 192'(0));
    chk("midrst_out_valid", 192'(bus0.out_valid), 192'(0));
    chk("midrst_in_ready", 192'(bus0.in_ready), 192'(1));
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 12; i++) words[i] = stream1[11 - i];
    send_stream(-1, 0);
    pulse_out_ready();

    // 1x1 loader
    e1.a   = {160'b0, 32'h3F800000};
    e1.b   = {160'b0, 32'h40000000};
    e1.cyc = cyc + 2;
    q1.push_back(e1);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 32'h3F800000;
    step();
    bus1.in_data  = 32'h40000000;
    step();
    bus1.in_valid = 1'b0;
    step();
    chk("one_hold_A", 192'(bus1.A), 192'(32'h3F800000));
    chk("one_out_valid", 192'(bus1.out_valid), 192'(1));

    repeat (3) step();
    chk("pairs_left0", 192'(q0.size()), 192'(0));
    chk("pairs_left1", 192'(q1.size()), 192'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
